// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants.
// Used by the fetch stage and its skid buffer.
package pipeline_pkg;

  localparam int unsigned PC_WIDTH    = 8;
  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned OPCODE_HI   = 31;
  localparam int unsigned OPCODE_LO   = 26;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  localparam logic [INSTR_WIDTH-1:0] NOP = '0;

  typedef enum logic [1:0] {
    REQ,
    HOLD,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer holding a fetched word
// and its PC+1 while the IF/ID latch is stalled.
module fetch_skid_buffer #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic          drain_i,
  input  logic [DW-1:0] data_i,
  input  logic [AW-1:0] pcn_i,
  output logic          full_o,
  output logic [DW-1:0] data_o,
  output logic [AW-1:0] pcn_o
);

  logic          full_q;
  logic [DW-1:0] data_q;
  logic [AW-1:0] pcn_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      pcn_q  <= '0;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q <= 1'b1;
      data_q <= data_i;
      pcn_q  <= pcn_i;
    end else if (drain_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;
  assign pcn_o  = pcn_q;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, talks req/ready to imem,
// skids one stalled word, redirects and halts.
module instruction_fetch #(
  parameter int unsigned PC_WIDTH    = pipeline_pkg::PC_WIDTH,
  parameter int unsigned INSTR_WIDTH = pipeline_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [5:0] HALT_OPCODE  = pipeline_pkg::HALT_OPCODE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall_IF,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   enableDebug,
  input  logic                   resetDebug,
  output logic [PC_WIDTH-1:0]    programCounter_out,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic                   instr_valid,
  output logic                   halted,
  output logic [15:0]            fetch_count
);

  import pipeline_pkg::*;

  fetch_state_e state_q, state_d;

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   req_q, req_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pcout_q, pcout_d;
  logic                   valid_q, valid_d;
  logic                   halted_q, halted_d;
  logic [15:0]            count_q, count_d;
  logic                   squash_q, squash_d;

  logic                   xfer;
  logic                   buf_load;
  logic                   buf_drain;
  logic                   buf_clr;
  logic                   buf_full;
  logic [INSTR_WIDTH-1:0] buf_data;
  logic [PC_WIDTH-1:0]    buf_pcn;

  function automatic logic is_halt(
    input logic [INSTR_WIDTH-1:0] w
  );
    return w[OPCODE_HI:OPCODE_LO] == HALT_OPCODE;
  endfunction

  assign xfer = req_q & imem_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    pcout_d   = pcout_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    count_d   = count_q;
    squash_d  = squash_q;
    buf_load  = 1'b0;
    buf_drain = 1'b0;
    buf_clr   = 1'b0;

    if (resetDebug) begin
      state_d  = REQ;
      pc_d     = RESET_PC;
      req_d    = 1'b0;
      addr_d   = '0;
      instr_d  = NOP;
      pcout_d  = '0;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      count_d  = '0;
      squash_d = 1'b0;
      buf_clr  = 1'b1;
    end else if (branch_taken
                 && state_q != HALT) begin
      state_d = REQ;
      pc_d    = branch_target;
      buf_clr = 1'b1;
      instr_d = NOP;
      valid_d = 1'b0;
      // A pending request must finish at its old address
      if (req_q && !imem_ready) begin
        squash_d = 1'b1;
      end else begin
        squash_d = 1'b0;
        req_d    = 1'b1;
        addr_d   = branch_target;
      end
    end else if (!enableDebug) begin
      if (xfer) begin
        req_d = 1'b0;
        if (squash_q) begin
          squash_d = 1'b0;
        end else begin
          buf_load = 1'b1;
          pc_d     = pc_q + 1'b1;
          state_d  = HOLD;
        end
      end
    end else begin
      unique case (state_q)
        REQ: begin
          if (xfer && squash_q) begin
            squash_d = 1'b0;
            req_d    = 1'b1;
            addr_d   = pc_q;
            if (!stall_IF) begin
              instr_d = NOP;
              valid_d = 1'b0;
            end
          end else if (xfer) begin
            pc_d = pc_q + 1'b1;
            if (stall_IF) begin
              buf_load = 1'b1;
              state_d  = HOLD;
              req_d    = 1'b0;
            end else begin
              instr_d = imem_rdata;
              pcout_d = addr_q + 1'b1;
              valid_d = 1'b1;
              if (count_q != 16'hFFFF)
                count_d = count_q + 1'b1;
              if (is_halt(imem_rdata)) begin
                state_d  = HALT;
                halted_d = 1'b1;
                req_d    = 1'b0;
              end else begin
                req_d  = 1'b1;
                addr_d = pc_q + 1'b1;
              end
            end
          end else begin
            req_d = 1'b1;
            if (!req_q)
              addr_d = pc_q;
            if (!stall_IF) begin
              instr_d = NOP;
              valid_d = 1'b0;
            end
          end
        end
        HOLD: begin
          if (!stall_IF && buf_full) begin
            buf_drain = 1'b1;
            instr_d   = buf_data;
            pcout_d   = buf_pcn;
            valid_d   = 1'b1;
            if (count_q != 16'hFFFF)
              count_d = count_q + 1'b1;
            if (is_halt(buf_data)) begin
              state_d  = HALT;
              halted_d = 1'b1;
            end else begin
              state_d = REQ;
              req_d   = 1'b1;
              addr_d  = pc_q;
            end
          end
        end
        HALT: begin
          req_d = 1'b0;
          if (!stall_IF) begin
            instr_d = NOP;
            valid_d = 1'b0;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= '0;
      instr_q  <= NOP;
      pcout_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      pcout_q  <= pcout_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      count_q  <= count_d;
      squash_q <= squash_d;
    end
  end

  fetch_skid_buffer #(
    .DW (INSTR_WIDTH),
    .AW (PC_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (buf_clr),
    .load_i  (buf_load),
    .drain_i (buf_drain),
    .data_i  (imem_rdata),
    .pcn_i   (addr_q + 1'b1),
    .full_o  (buf_full),
    .data_o  (buf_data),
    .pcn_o   (buf_pcn)
  );

  assign imem_req           = req_q;
  assign imem_addr          = addr_q;
  assign instruction_out    = instr_q;
  assign programCounter_out = pcout_q;
  assign instr_valid        = valid_q;
  assign halted             = halted_q;
  assign fetch_count        = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for the IF stage with a
// combinational word-per-address memory model.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        stall_IF;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        enableDebug;
  logic        resetDebug;
  logic [7:0]  programCounter_out;
  logic [31:0] instruction_out;
  logic        instr_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [256];

  int n_chk;
  int n_fail;

  instruction_fetch dut (
    .clk                (clk),
    .reset              (reset),
    .stall_IF           (stall_IF),
    .branch_taken       (branch_taken),
    .branch_target      (branch_target),
    .imem_req           (imem_req),
    .imem_addr          (imem_addr),
    .imem_ready         (imem_ready),
    .imem_rdata         (imem_rdata),
    .enableDebug        (enableDebug),
    .resetDebug         (resetDebug),
    .programCounter_out (programCounter_out),
    .instruction_out    (instruction_out),
    .instr_valid        (instr_valid),
    .halted             (halted),
    .fetch_count        (fetch_count)
  );

  assign imem_rdata = mem[imem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " req"}, 32'(imem_req), 0);
    chk({tag, " addr"}, 32'(imem_addr), 0);
    chk({tag, " instr"}, instruction_out, 0);
    chk({tag, " pcout"},
        32'(programCounter_out), 0);
    chk({tag, " valid"}, 32'(instr_valid), 0);
    chk({tag, " halted"}, 32'(halted), 0);
    chk({tag, " count"}, 32'(fetch_count), 0);
  endtask

  task automatic chk_out(
    input string       tag,
    input logic [31:0] ins,
    input logic [7:0]  pco,
    input logic [15:0] cnt
  );
    chk({tag, " valid"}, 32'(instr_valid), 1);
    chk({tag, " instr"}, instruction_out, ins);
    chk({tag, " pcout"},
        32'(programCounter_out), 32'(pco));
    chk({tag, " count"},
        32'(fetch_count), 32'(cnt));
  endtask

  initial begin
    int req_hi;
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++)
      mem[i] = 32'h1000_0000 + i;

    reset         = 1'b1;
    stall_IF      = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 8'h00;
    imem_ready    = 1'b1;
    enableDebug   = 1'b1;
    resetDebug    = 1'b0;

    // reset and first fetches
    #2 reset = 1'b0;
    #1 chk_zero("rst");
    #9 reset = 1'b1;
    tick();
    chk("first req", 32'(imem_req), 1);
    chk("first addr", 32'(imem_addr), 0);
    chk("first valid", 32'(instr_valid), 0);
    tick();
    chk_out("i0", 32'h1000_0000, 8'h01, 16'd1);
    tick();
    chk_out("i1", 32'h1000_0001, 8'h02, 16'd2);
    tick();
    chk_out("i2", 32'h1000_0002, 8'h03, 16'd3);
    chk("i2 addr", 32'(imem_addr), 3);

    // stall with a transfer in flight
    stall_IF = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall req", 32'(imem_req), 0);
      chk_out("stall hold", 32'h1000_0002,
              8'h03, 16'd3);
    end
    stall_IF = 1'b0;
    tick();
    chk_out("drain", 32'h1000_0003, 8'h04, 16'd4);
    chk("drain req", 32'(imem_req), 1);
    chk("drain addr", 32'(imem_addr), 4);
    tick();
    chk_out("i4", 32'h1000_0004, 8'h05, 16'd5);

    // branch during a delayed response
    imem_ready    = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 8'h40;
    tick();
    branch_taken = 1'b0;
    chk("br req", 32'(imem_req), 1);
    chk("br addr", 32'(imem_addr), 5);
    chk("br valid", 32'(instr_valid), 0);
    chk("br instr", instruction_out, 0);
    tick();
    chk("wait addr", 32'(imem_addr), 5);
    imem_ready = 1'b1;
    tick();
    chk("sq addr", 32'(imem_addr), 8'h40);
    chk("sq valid", 32'(instr_valid), 0);
    chk("sq count", 32'(fetch_count), 5);
    tick();
    chk_out("tgt", 32'h1000_0040, 8'h41, 16'd6);

    // redirect near the top and wrap
    branch_taken  = 1'b1;
    branch_target = 8'hFE;
    tick();
    branch_taken = 1'b0;
    chk("wr addr", 32'(imem_addr), 8'hFE);
    chk("wr valid", 32'(instr_valid), 0);
    tick();
    chk_out("wFE", 32'h1000_00FE, 8'hFF, 16'd7);
    chk("wFE addr", 32'(imem_addr), 8'hFF);
    tick();
    chk_out("wFF", 32'h1000_00FF, 8'h00, 16'd8);
    chk("wFF addr", 32'(imem_addr), 8'h00);
    tick();
    chk_out("w00", 32'h1000_0000, 8'h01, 16'd9);

    // soft reset mid-run
    resetDebug = 1'b1;
    mem[3] = 32'hFC00_0003;
    tick();
    chk_zero("rdbg");
    resetDebug = 1'b0;

    // halt on word 3
    for (int k = 0; k < 4; k++)
      tick();
    chk("pre halt", 32'(halted), 0);
    tick();
    chk_out("halt", 32'hFC00_0003, 8'h04, 16'd4);
    chk("halt flag", 32'(halted), 1);
    chk("halt req", 32'(imem_req), 0);
    req_hi = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (imem_req)
        req_hi++;
    end
    chk("halt req10", 32'(req_hi), 0);
    chk("halt bubble", 32'(instr_valid), 0);
    branch_taken  = 1'b1;
    branch_target = 8'h20;
    tick();
    branch_taken = 1'b0;
    tick();
    chk("hbr halted", 32'(halted), 1);
    chk("hbr req", 32'(imem_req), 0);
    chk("hbr addr", 32'(imem_addr), 3);
    chk("hbr count", 32'(fetch_count), 4);

    // async reset while a request waits
    resetDebug = 1'b1;
    tick();
    resetDebug = 1'b0;
    imem_ready = 1'b0;
    tick();
    tick();
    chk("wait req", 32'(imem_req), 1);
    #2 reset = 1'b0;
    #1 chk_zero("arst");
    #3 reset = 1'b1;
    tick();

    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
